// File: rtl/zbt_port_arbiter_if.sv
// Bus bundle between the ZBT port arbiter, the NTSC capture path, the display
// reader and the ZBT SRAM. The arbiter uses the slave modport, the
// environment uses the master modport.
// Optional: ZBT_ARB_STATS_EN adds the drop_count statistic.
interface zbt_port_arbiter_if;
    logic        ntsc_we;
    logic [18:0] ntsc_addr;
    logic [35:0] ntsc_data;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        disp_ready;
    logic [35:0] disp_data;
    logic        disp_valid;
    logic [18:0] ram_addr;
    logic        ram_we_b;
    logic [35:0] ram_wdata;
    logic [35:0] ram_rdata;
    logic        ntsc_overflow;
`ifdef ZBT_ARB_STATS_EN
    logic [15:0] drop_count;
`endif

    modport slave (
`ifdef ZBT_ARB_STATS_EN
        output drop_count,
`endif
        input  ntsc_we, ntsc_addr, ntsc_data, disp_req, disp_addr, ram_rdata,
        output disp_ready, disp_data, disp_valid, ram_addr, ram_we_b, ram_wdata,
        output ntsc_overflow
    );

    modport master (
`ifdef ZBT_ARB_STATS_EN
        input  drop_count,
`endif
        output ntsc_we, ntsc_addr, ntsc_data, disp_req, disp_addr, ram_rdata,
        input  disp_ready, disp_data, disp_valid, ram_addr, ram_we_b, ram_wdata,
        input  ntsc_overflow
    );
endinterface

// File: rtl/zbt_port_arbiter.sv
// ZBT SRAM port arbiter: shares one pipelined ZBT port between buffered NTSC
// writes and display reads. Reads win unless a pending write has been
// deferred STARVE_LIMIT times, in which case the write is forced.
// Optional: define ZBT_ARB_STATS_EN to add the saturating drop_count output.
module zbt_port_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               reset,
    zbt_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DEF_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SlotIdle, SlotRead, SlotWrite} slot_e;

    // Write buffer
    logic [18:0]      fifo_addr_q [FIFO_DEPTH];
    logic [35:0]      fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEF_W-1:0] defer_cnt_q;

    // Write-data and read-return pipelines matching ZBT latency
    logic        wv1_q, wv2_q;
    logic [35:0] wd1_q, wd2_q;
    logic        rv1_q, rv2_q;

    slot_e slot;
    logic  fifo_empty;
    logic  fifo_full;
    logic  force_write;
    logic  push;
    logic  pop;
    logic  drop;

    // Slot decision and FIFO push/pop qualification for the current cycle
    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
        force_write = !fifo_empty && (defer_cnt_q == DEF_W'(STARVE_LIMIT));
        if (reset) begin
            slot = SlotIdle;
        end else if (force_write) begin
            slot = SlotWrite;
        end else if (bus.disp_req) begin
            slot = SlotRead;
        end else if (!fifo_empty) begin
            slot = SlotWrite;
        end else begin
            slot = SlotIdle;
        end
        pop  = (slot == SlotWrite);
        // A full FIFO still accepts a push when the head leaves this cycle
        push = bus.ntsc_we && !reset && (!fifo_full || pop);
        drop = bus.ntsc_we && !reset && fifo_full && !pop;
    end

    assign bus.disp_ready = (slot == SlotRead);

    // FIFO storage; contents need no reset since count_q gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.ntsc_addr;
            fifo_data_q[wr_ptr_q] <= bus.ntsc_data;
        end
    end

    // FIFO pointers, occupancy, starvation counter and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            defer_cnt_q       <= '0;
            bus.ntsc_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (slot == SlotWrite) begin
                defer_cnt_q <= '0;
            end else if (slot == SlotRead && !fifo_empty &&
                         defer_cnt_q != DEF_W'(STARVE_LIMIT)) begin
                defer_cnt_q <= defer_cnt_q + DEF_W'(1);
            end
            if (drop) begin
                bus.ntsc_overflow <= 1'b1;
            end
        end
    end

    // Registered ZBT address/control; IDLE slots keep the last address
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ram_addr <= '0;
            bus.ram_we_b <= 1'b1;
        end else begin
            unique case (slot)
                SlotRead: begin
                    bus.ram_addr <= bus.disp_addr;
                    bus.ram_we_b <= 1'b1;
                end
                SlotWrite: begin
                    bus.ram_addr <= fifo_addr_q[rd_ptr_q];
                    bus.ram_we_b <= 1'b0;
                end
                default: begin
                    bus.ram_we_b <= 1'b1;
                end
            endcase
        end
    end

    // Write data lags its address cycle by two clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            wv1_q         <= 1'b0;
            wv2_q         <= 1'b0;
            wd1_q         <= '0;
            wd2_q         <= '0;
            bus.ram_wdata <= '0;
        end else begin
            wv1_q <= pop;
            wd1_q <= fifo_data_q[rd_ptr_q];
            wv2_q <= wv1_q;
            wd2_q <= wd1_q;
            if (wv2_q) begin
                bus.ram_wdata <= wd2_q;
            end
        end
    end

    // Read return: valid three cycles after acceptance, data latched from ZBT
    always_ff @(posedge clk) begin
        if (reset) begin
            rv1_q          <= 1'b0;
            rv2_q          <= 1'b0;
            bus.disp_valid <= 1'b0;
            bus.disp_data  <= '0;
        end else begin
            rv1_q          <= (slot == SlotRead);
            rv2_q          <= rv1_q;
            bus.disp_valid <= rv2_q;
            if (rv2_q) begin
                bus.disp_data <= bus.ram_rdata;
            end
        end
    end

`ifdef ZBT_ARB_STATS_EN
    logic [15:0] drop_count_q;

    // Saturating count of dropped write strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
        end else if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign bus.drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Self-checking bench for zbt_port_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_zbt_port_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;
    localparam int S_IDLE  = 0;
    localparam int S_READ  = 1;
    localparam int S_WRITE = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    zbt_port_arbiter_if bus ();

    zbt_port_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] ram_f(input logic [18:0] a);
        return {a[16:0], a} ^ 36'h9_A5C3_1E7B;
    endfunction

    // ZBT read model: data for the address seen in one cycle appears the next
    always @(posedge clk) bus.ram_rdata <= ram_f(bus.ram_addr);

    // Behavioural model state
    logic [54:0] mq[$];
    int          defer;
    bit          e_ovf;
    int          drops;
    logic [18:0] e_addr;
    bit          e_web;
    logic [35:0] e_wdata;
    logic [35:0] e_ddata;
    bit          e_valid;
    int          h_slot[3];
    logic [54:0] h_pay[3];

    task automatic model_reset();
        mq.delete();
        defer   = 0;
        e_ovf   = 1'b0;
        drops   = 0;
        e_addr  = '0;
        e_web   = 1'b1;
        e_wdata = '0;
        e_ddata = '0;
        e_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            h_slot[i] = S_IDLE;
            h_pay[i]  = '0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    // One clock cycle: drive inputs, check disp_ready, advance model, check outputs
    task automatic step(input bit rst, input bit we, input logic [18:0] wa,
                        input logic [35:0] wd, input bit rq, input logic [18:0] ra);
        int          slot;
        bit          nonempty;
        logic [54:0] front;
        logic [54:0] pay;
        reset         = rst;
        bus.ntsc_we   = we;
        bus.ntsc_addr = wa;
        bus.ntsc_data = wd;
        bus.disp_req  = rq;
        bus.disp_addr = ra;
        #1;
        nonempty = (mq.size() > 0);
        front    = nonempty ? mq[0] : 55'd0;
        if (rst) slot = S_IDLE;
        else if (nonempty && defer == LIMIT) slot = S_WRITE;
        else if (rq) slot = S_READ;
        else if (nonempty) slot = S_WRITE;
        else slot = S_IDLE;
        chk("disp_ready", 64'(bus.disp_ready), 64'(slot == S_READ));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            pay = '0;
            if (slot == S_READ) begin
                e_addr = ra;
                pay    = {ra, 36'd0};
            end else if (slot == S_WRITE) begin
                e_addr = front[54:36];
                pay    = front;
                void'(mq.pop_front());
            end
            e_web = (slot != S_WRITE);
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back({wa, wd});
                else begin
                    e_ovf = 1'b1;
                    if (drops < 65535) drops++;
                end
            end
            if (slot == S_WRITE) defer = 0;
            else if (slot == S_READ && nonempty && defer < LIMIT) defer++;
            h_slot[2] = h_slot[1]; h_pay[2] = h_pay[1];
            h_slot[1] = h_slot[0]; h_pay[1] = h_pay[0];
            h_slot[0] = slot;      h_pay[0] = pay;
            e_valid = (h_slot[2] == S_READ);
            if (h_slot[2] == S_READ) e_ddata = ram_f(h_pay[2][54:36]);
            if (h_slot[2] == S_WRITE) e_wdata = h_pay[2][35:0];
        end
        @(negedge clk);
        chk("ram_addr", 64'(bus.ram_addr), 64'(e_addr));
        chk("ram_we_b", 64'(bus.ram_we_b), 64'(e_web));
        chk("ram_wdata", 64'(bus.ram_wdata), 64'(e_wdata));
        chk("disp_valid", 64'(bus.disp_valid), 64'(e_valid));
        chk("disp_data", 64'(bus.disp_data), 64'(e_ddata));
        chk("ntsc_overflow", 64'(bus.ntsc_overflow), 64'(e_ovf));
`ifdef ZBT_ARB_STATS_EN
        chk("drop_count", 64'(bus.drop_count), 64'(drops));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [63:0] r;
        reset         = 1'b1;
        bus.ntsc_we   = 1'b0;
        bus.ntsc_addr = '0;
        bus.ntsc_data = '0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        model_reset();
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 19'h7, 36'h7, 1'b1, 19'h5);

        // Single write while idle
        step(1'b0, 1'b1, 19'h00123, 36'hA5, 1'b0, '0);
        idle(5);

        // Single read
        step(1'b0, 1'b0, '0, '0, 1'b1, 19'h00040);
        idle(5);

        // Starvation: one queued write under continuous reads
        step(1'b0, 1'b1, 19'h00321, 36'h5A5A, 1'b1, 19'h00100);
        for (int i = 1; i < 14; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 19'(32'h100 + i));
        idle(5);

        // Overflow: five strobes under continuous reads
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 19'(32'h200 + i), 36'(64'h1000 + i), 1'b1, 19'(32'h300 + i));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 19'(32'h400 + i));
        idle(12);

        // Reset with reads in flight and writes queued
        step(1'b0, 1'b1, 19'h00501, 36'h501, 1'b1, 19'h00601);
        step(1'b0, 1'b1, 19'h00502, 36'h502, 1'b1, 19'h00602);
        step(1'b0, 1'b0, '0, '0, 1'b1, 19'h00603);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        idle(6);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom()};
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 19'($urandom()),
                 r[35:0], ($urandom_range(0, 3) != 0), 19'($urandom()));
        end
        idle(8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
